// File: rtl/des_key_sched_ctrl.sv
// DES key schedule sequencer: PC-1 load, per-step C/D rotation, PC-2 subkey stream.
// Optional byte parity check on the key is enabled by DES_KEY_PARITY_CHECK_EN.
module des_key_sched_ctrl (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic        abort,
  input  logic [63:0] key_in,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  round_idx,
  output logic        busy,
  output logic        done,
  output logic        key_err
);

  localparam int NUM_ROUNDS = 16;
  localparam logic [3:0] LAST = 4'(NUM_ROUNDS - 1);

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Table entries are FIPS bit numbers, bit 1 being the MSB.
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      r[55-i] = k[64-PC1_T[i]];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      r[47-i] = cd[56-PC2_T[i]];
    end
    return r;
  endfunction

  // Decrypt starts from C16/D16 (== C0/D0) and undoes the shifts in reverse.
  function automatic logic [1:0] shamt(
    input logic [3:0] step,
    input logic       dec
  );
    logic [1:0] n;
    n = 2'd2;
    if (dec) begin
      if (step == 4'd0) begin
        n = 2'd0;
      end else if (step == 4'd1 || step == 4'd8 || step == 4'd15) begin
        n = 2'd1;
      end
    end else begin
      if (step == 4'd0 || step == 4'd1 || step == 4'd8 || step == 4'd15) begin
        n = 2'd1;
      end
    end
    return n;
  endfunction

  function automatic logic [27:0] rot(
    input logic [27:0] x,
    input logic [1:0]  n,
    input logic        dec
  );
    logic [27:0] r;
    r = x;
    unique case ({dec, n})
      3'b001:  r = {x[26:0], x[27]};
      3'b010:  r = {x[25:0], x[27:26]};
      3'b101:  r = {x[0], x[27:1]};
      3'b110:  r = {x[1:0], x[27:2]};
      default: r = x;
    endcase
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [27:0] c_q, c_d;
  logic [27:0] d_q, d_d;
  logic [3:0]  idx_q, idx_d;
  logic        dec_q, dec_d;
  logic        err_q, err_d;
  logic        key_ok;
  logic [55:0] cd_ld;
  logic [3:0]  idx_nx;
  logic [1:0]  sh_ld;
  logic [1:0]  sh_nx;

`ifdef DES_KEY_PARITY_CHECK_EN
  always_comb begin
    key_ok = 1'b1;
    for (int b = 0; b < 8; b++) begin
      key_ok = key_ok & (^key_in[8*b +: 8]);
    end
  end
  assign key_err = err_q;
`else
  logic unused_parity;
  assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                           key_in[24], key_in[16], key_in[8], key_in[0], err_q};
  assign key_ok  = 1'b1;
  assign key_err = 1'b0;
`endif

  assign cd_ld  = pc1(key_in);
  assign idx_nx = idx_q + 4'd1;
  assign sh_ld  = shamt(4'd0, decrypt);
  assign sh_nx  = shamt(idx_nx, dec_q);

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    idx_d   = idx_q;
    dec_d   = dec_q;
    err_d   = err_q;
    if (abort) begin
      state_d = IDLE;
      idx_d   = 4'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (key_ok) begin
              err_d   = 1'b0;
              dec_d   = decrypt;
              c_d     = rot(cd_ld[55:28], sh_ld, decrypt);
              d_d     = rot(cd_ld[27:0], sh_ld, decrypt);
              idx_d   = 4'd0;
              state_d = RUN;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        RUN: begin
          if (subkey_ready) begin
            if (idx_q == LAST) begin
              state_d = DONE;
            end else begin
              c_d   = rot(c_q, sh_nx, dec_q);
              d_d   = rot(d_q, sh_nx, dec_q);
              idx_d = idx_nx;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      idx_q   <= '0;
      dec_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      idx_q   <= idx_d;
      dec_q   <= dec_d;
      err_q   <= err_d;
    end
  end

  assign subkey       = pc2({c_q, d_q});
  assign subkey_valid = (state_q == RUN);
  assign busy         = (state_q == RUN) || (state_q == DONE);
  assign done         = (state_q == DONE);
  assign round_idx    = idx_q;

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Bench for des_key_sched_ctrl: cumulative-shift key schedule model plus
// directed runs (encrypt, decrypt, backpressure, abort, reset, parity).
module tb_des_key_sched_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        start = 1'b0;
  logic        decrypt = 1'b0;
  logic        abort = 1'b0;
  logic [63:0] key_in = '0;
  logic        subkey_ready = 1'b0;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic [3:0]  round_idx;
  logic        busy;
  logic        done;
  logic        key_err;

  des_key_sched_ctrl dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .start        (start),
    .decrypt      (decrypt),
    .abort        (abort),
    .key_in       (key_in),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .round_idx    (round_idx),
    .busy         (busy),
    .done         (done),
    .key_err      (key_err)
  );

  always #5 Clk = ~Clk;

`ifdef DES_KEY_PARITY_CHECK_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;
  localparam logic [47:0] K1_A  = 48'h1B02EFFC7072;
  localparam logic [47:0] K16_A = 48'hCB3D8B0E17F5;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  int n_cmp = 0;
  int n_bad = 0;
  int hs = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Textbook Kn: C0/D0 rotated left by the running total of shifts.
  function automatic logic [47:0] ks(input logic [63:0] k, input int n);
    logic [55:0] p;
    logic [55:0] cd;
    logic [27:0] c;
    logic [27:0] d;
    logic [47:0] r;
    int tot;
    for (int i = 0; i < 56; i++) p[55-i] = k[64-PC1_T[i]];
    c = p[55:28];
    d = p[27:0];
    tot = 0;
    for (int i = 0; i < n; i++) tot += SH_T[i];
    for (int i = 0; i < tot; i++) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    cd = {c, d};
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2_T[i]];
    return r;
  endfunction

  function automatic bit par_ok(input logic [63:0] k);
    bit ok;
    ok = 1'b1;
    for (int b = 0; b < 8; b++) begin
      if ($countones(k[8*b +: 8]) % 2 == 0) ok = 1'b0;
    end
    return ok;
  endfunction

  // Model: 0 idle, 1 streaming subkeys, 2 done pulse.
  int          m_state;
  int          m_idx;
  logic        m_dec;
  logic [63:0] m_key;
  logic        m_err;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_state <= 0;
      m_idx   <= 0;
      m_err   <= 1'b0;
      m_dec   <= 1'b0;
      m_key   <= '0;
    end else if (abort) begin
      m_state <= 0;
      m_idx   <= 0;
    end else begin
      case (m_state)
        0: if (start) begin
          if (!PAR || par_ok(key_in)) begin
            m_state <= 1;
            m_idx   <= 0;
            m_dec   <= decrypt;
            m_key   <= key_in;
            m_err   <= 1'b0;
          end else begin
            m_err <= 1'b1;
          end
        end
        1: if (subkey_ready) begin
          if (m_idx == 15) m_state <= 2;
          else m_idx <= m_idx + 1;
        end
        default: m_state <= 0;
      endcase
    end
  end

  always @(negedge Clk) begin
    if (Reset_n) begin
      chk("subkey_valid", subkey_valid, m_state == 1);
      chk("busy", busy, m_state != 0);
      chk("done", done, m_state == 2);
      chk("key_err", key_err, m_err);
      if (m_state == 1) begin
        chk("round_idx", round_idx, m_idx);
        chk("subkey", subkey, ks(m_key, m_dec ? 16 - m_idx : m_idx + 1));
      end
      if (!busy) hs = 0;
      if (subkey_valid && subkey_ready) hs++;
      if (done) chk("handshakes", hs, 16);
    end
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic run(input logic [63:0] k, input logic dec, input bit rnd,
                     input bit mid_start, input int abort_at,
                     input logic [47:0] lit0, input logic [47:0] lit15,
                     input bit use_lit);
    int vcnt;
    int cyc;
    vcnt = 0;
    key_in = k;
    decrypt = dec;
    subkey_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    key_in = ~k;
    decrypt = ~dec;
    chk("first_valid", subkey_valid, 1'b1);
    for (cyc = 0; cyc < 300 && m_state != 0; cyc++) begin
      subkey_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = mid_start && (cyc % 3 == 0);
      abort = (m_state == 1) && (m_idx == abort_at);
      if (use_lit && m_state == 1 && m_idx == 0) chk("lit_idx0", subkey, lit0);
      if (use_lit && m_state == 1 && m_idx == 15) chk("lit_idx15", subkey, lit15);
      if (subkey_valid) vcnt++;
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    chk("run_timeout", m_state, 0);
    if (!rnd && abort_at < 0) chk("valid_cycles", vcnt, 16);
  endtask

  initial begin
    #3;
    chk("rst_subkey", subkey, 48'h0);
    chk("rst_valid", subkey_valid, 1'b0);
    chk("rst_idx", round_idx, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_key_err", key_err, 1'b0);
    tick();
    Reset_n = 1'b1;
    repeat (3) tick();

    run(KEY_A, 1'b0, 1'b0, 1'b0, -1, K1_A, K16_A, 1'b1);
    repeat (2) tick();
    run(KEY_A, 1'b1, 1'b0, 1'b0, -1, K16_A, K1_A, 1'b1);
    tick();
    run(KEY_A, 1'b0, 1'b1, 1'b1, -1, K1_A, K16_A, 1'b1);
    run(KEY_B, 1'b1, 1'b1, 1'b1, -1, '0, '0, 1'b0);
    run(KEY_B, 1'b0, 1'b0, 1'b0, 5, '0, '0, 1'b0);
    repeat (2) tick();

    start = 1'b1;
    abort = 1'b1;
    key_in = KEY_A;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start_busy", busy, 1'b0);
    tick();

    key_in = KEY_B;
    decrypt = 1'b0;
    subkey_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    #1;
    Reset_n = 1'b0;
    #1;
    chk("midrst_valid", subkey_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_idx", round_idx, 4'd0);
    chk("midrst_subkey", subkey, 48'h0);
    chk("midrst_done", done, 1'b0);
    #1;
    Reset_n = 1'b1;
    tick();
    run(KEY_A, 1'b0, 1'b0, 1'b0, -1, K1_A, K16_A, 1'b1);

`ifdef DES_KEY_PARITY_CHECK_EN
    key_in = 64'h0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("par_err", key_err, 1'b1);
    chk("par_busy", busy, 1'b0);
    repeat (2) tick();
    run(KEY_A, 1'b0, 1'b0, 1'b0, -1, K1_A, K16_A, 1'b1);
    chk("par_cleared", key_err, 1'b0);
`endif

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
